// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: per-register outstanding-write counts and producer tnew.
// Optional macro SCOREBOARD_FORWARD_EN enables bypass selection instead of stalling.
module reg_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  input  logic [1:0] issue_tnew,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       rs_used,
  input  logic       rt_used,
  input  logic [1:0] rs_tuse,
  input  logic [1:0] rt_tuse,
  input  logic       wb_we,
  input  logic [4:0] wb_a3,
  output logic       stall,
  output logic       rs_fwd,
  output logic       rt_fwd,
  output logic [5:0] busy_cnt
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned BW   = 6;

  logic [1:0]      cnt_q  [NREG];
  logic [1:0]      cnt_d  [NREG];
  logic [1:0]      tnew_q [NREG];
  logic [1:0]      tnew_d [NREG];
  logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [NREG-1:0] inc_v, dec_v;

  logic rs_hz, rt_hz, rs_late, rt_late, full, accept;
  logic rs_fwd_c, rt_fwd_c, stall_c;

  // A source is not hazarded when its last pending write commits this cycle.
  always_comb begin
    rs_hz = rs_used && (rs_addr != 5'd0) && (cnt_q[rs_addr] != 2'd0) &&
            !(wb_we && (wb_a3 == rs_addr) && (cnt_q[rs_addr] == 2'd1));
    rt_hz = rt_used && (rt_addr != 5'd0) && (cnt_q[rt_addr] != 2'd0) &&
            !(wb_we && (wb_a3 == rt_addr) && (cnt_q[rt_addr] == 2'd1));
    full  = (issue_rd != 5'd0) && (cnt_q[issue_rd] == 2'd3);
  end

`ifdef SCOREBOARD_FORWARD_EN
  always_comb begin
    rs_late  = rs_hz && (tnew_q[rs_addr] > rs_tuse);
    rt_late  = rt_hz && (tnew_q[rt_addr] > rt_tuse);
    rs_fwd_c = issue_valid && rs_hz && !rs_late;
    rt_fwd_c = issue_valid && rt_hz && !rt_late;
  end
`else
  logic tuse_unused;
  assign tuse_unused = ^{rs_tuse, rt_tuse};
  always_comb begin
    rs_late  = rs_hz;
    rt_late  = rt_hz;
    rs_fwd_c = 1'b0;
    rt_fwd_c = 1'b0;
  end
`endif

  assign stall_c = issue_valid && (full || rs_late || rt_late);
  assign accept  = issue_valid && !stall_c;

  // Per-register issue (increment) and commit (decrement) strobes.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      inc_v[i] = accept && (issue_rd == AW'(i));
      dec_v[i] = wb_we && (wb_a3 == AW'(i)) && (cnt_q[i] != 2'd0);
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i]  = cnt_q[i];
      tnew_d[i] = (tnew_q[i] != 2'd0) ? (tnew_q[i] - 2'd1) : 2'd0;
      if (i == 0) begin
        cnt_d[i]  = 2'd0;
        tnew_d[i] = 2'd0;
      end else begin
        if (inc_v[i] && !dec_v[i])      cnt_d[i] = cnt_q[i] + 2'd1;
        else if (dec_v[i] && !inc_v[i]) cnt_d[i] = cnt_q[i] - 2'd1;
        if (inc_v[i])                   tnew_d[i] = issue_tnew;
      end
      busy_cnt_d = busy_cnt_d + BW'(cnt_d[i] != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i]  <= 2'd0;
        tnew_q[i] <= 2'd0;
      end
      busy_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i]  <= cnt_d[i];
        tnew_q[i] <= tnew_d[i];
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign stall    = stall_c;
  assign rs_fwd   = rs_fwd_c;
  assign rt_fwd   = rt_fwd_c;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow SCOREBOARD_FORWARD_EN when defined.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [1:0] issue_tnew;
  logic [4:0] rs_addr, rt_addr;
  logic       rs_used, rt_used;
  logic [1:0] rs_tuse, rt_tuse;
  logic       wb_we;
  logic [4:0] wb_a3;
  logic       stall, rs_fwd, rt_fwd;
  logic [5:0] busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tnew(issue_tnew),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .wb_we(wb_we), .wb_a3(wb_a3),
    .stall(stall), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_tnew = 2'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
    rs_tuse = 2'd0; rt_tuse = 2'd0; wb_we = 1'b0; wb_a3 = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] tn);
    issue_valid = 1'b1; issue_rd = rd; issue_tnew = tn;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    chk("reset_busy", 8'(busy_cnt), 8'd0);
    chk("reset_stall", 8'(stall), 8'd0);
    reset = 1'b0;

    // Plain issue, then watch the producer's tnew count down.
    issue(5'd8, 2'd2); #1;
    chk("issue8_stall", 8'(stall), 8'd0);
    tick(); idle();
    chk("issue8_busy", 8'(busy_cnt), 8'd1);
    chk("tnew8_t0", 8'(dut.tnew_q[8]), 8'd2);
    tick(); chk("tnew8_t1", 8'(dut.tnew_q[8]), 8'd1);
    tick(); chk("tnew8_t2", 8'(dut.tnew_q[8]), 8'd0);

    // Reader of a young producer.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_busy", 8'(busy_cnt), 8'd0);
    issue(5'd8, 2'd2); tick(); idle();
    issue_valid = 1'b1; rs_addr = 5'd8; rs_used = 1'b1; rs_tuse = 2'd0; #1;
    chk("raw_stall_c0", 8'(stall), 8'd1);
    chk("raw_fwd_c0", 8'(rs_fwd), 8'd0);
    tick(); #1;
    chk("raw_stall_c1", 8'(stall), 8'd1);
    tick(); #1;
`ifdef SCOREBOARD_FORWARD_EN
    chk("raw_stall_c2", 8'(stall), 8'd0);
    chk("raw_fwd_c2", 8'(rs_fwd), 8'd1);
`else
    chk("raw_stall_c2", 8'(stall), 8'd1);
    chk("raw_fwd_c2", 8'(rs_fwd), 8'd0);
`endif
    chk("raw_rtfwd_c2", 8'(rt_fwd), 8'd0);
    tick(); idle();

    // Last pending write commits in the same cycle as the read.
    chk("wt_busy_pre", 8'(busy_cnt), 8'd1);
    issue_valid = 1'b1; rs_addr = 5'd8; rs_used = 1'b1; wb_we = 1'b1; wb_a3 = 5'd8; #1;
    chk("wt_stall", 8'(stall), 8'd0);
    chk("wt_fwd", 8'(rs_fwd), 8'd0);
    tick(); idle();
    chk("wt_busy_post", 8'(busy_cnt), 8'd0);

    // Saturation of the outstanding count.
    for (int k = 0; k < 3; k++) begin
      issue(5'd5, 2'd0); #1;
      chk("sat_issue_stall", 8'(stall), 8'd0);
      tick();
    end
    chk("sat_busy", 8'(busy_cnt), 8'd1);
    #1;
    chk("sat_4th_stall", 8'(stall), 8'd1);
    tick(); #1;
    chk("sat_4th_held", 8'(stall), 8'd1);
    wb_we = 1'b1; wb_a3 = 5'd5; #1;
    chk("sat_wb_cycle", 8'(stall), 8'd1);
    tick(); wb_we = 1'b0; wb_a3 = 5'd0; #1;
    chk("sat_4th_accept", 8'(stall), 8'd0);
    tick(); #1;
    chk("sat_full_again", 8'(stall), 8'd1);
    idle();

    // rt source against the zero-tnew producer in reg 5.
    issue_valid = 1'b1; rt_addr = 5'd5; rt_used = 1'b1; rt_tuse = 2'd3; #1;
`ifdef SCOREBOARD_FORWARD_EN
    chk("rt_stall", 8'(stall), 8'd0);
    chk("rt_fwd", 8'(rt_fwd), 8'd1);
`else
    chk("rt_stall", 8'(stall), 8'd1);
    chk("rt_fwd", 8'(rt_fwd), 8'd0);
`endif
    issue_valid = 1'b0; #1;
    chk("novalid_stall", 8'(stall), 8'd0);
    chk("novalid_rtfwd", 8'(rt_fwd), 8'd0);
    idle();

    // Register 0 is never tracked.
    issue(5'd0, 2'd3); rs_addr = 5'd0; rs_used = 1'b1; wb_we = 1'b1; wb_a3 = 5'd0; #1;
    chk("r0_stall", 8'(stall), 8'd0);
    chk("r0_fwd", 8'(rs_fwd), 8'd0);
    tick(); idle();
    chk("r0_busy", 8'(busy_cnt), 8'd1);

    // Asynchronous reset with four busy registers.
    issue(5'd1, 2'd1); tick();
    issue(5'd2, 2'd2); tick();
    issue(5'd3, 2'd3); tick(); idle(); #1;
    chk("async_busy_pre", 8'(busy_cnt), 8'd4);
    issue(5'd5, 2'd0); #1;
    chk("async_stall_pre", 8'(stall), 8'd1);
    reset = 1'b1; #1;
    chk("async_busy", 8'(busy_cnt), 8'd0);
    chk("async_stall", 8'(stall), 8'd0);
    idle(); tick(); reset = 1'b0;
    issue(5'd9, 2'd0); #1;
    chk("post_rst_stall", 8'(stall), 8'd0);
    tick(); idle();
    chk("post_rst_busy", 8'(busy_cnt), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-003 SHALL have port issue_valid  input  1  D-stage instruction requests issue this cycle.
REQ-004 SHALL have port issue_rd  input  5  destination register of the issuing instruction; 0 means no write.
REQ-005 SHALL have port issue_tnew  input  2  cycles until the issuing instruction's result reaches the bypass point, range 0..3.
REQ-006 SHALL have ports rs_addr and rt_addr  input  5 each  source registers of the issuing instruction.
REQ-007 SHALL have ports rs_used and rt_used  input  1 each  the corresponding source is actually read.
REQ-008 SHALL have ports rs_tuse and rt_tuse  input  2 each  cycles until the corresponding source value is consumed.
REQ-009 SHALL have ports wb_we and wb_a3  input  1 and 5  write-back commit to the register file this cycle.
REQ-010 SHALL have port stall  output  1  combinational; issue must be held this cycle.
REQ-011 SHALL have ports rs_fwd and rt_fwd  output  1 each  combinational; source must be taken from the bypass network, not the register file.
REQ-012 SHALL have port busy_cnt  output  6  registered; number of registers with a nonzero outstanding count, range 0..31.

Function
REQ-013 SHALL hold per register 1..31 a 2-bit outstanding count (cnt) and a 2-bit tnew of the youngest producer; register 0 SHALL never be tracked.
REQ-014 SHALL define accept = issue_valid & !stall; on accept with issue_rd != 0, cnt[issue_rd] SHALL increment and tnew[issue_rd] SHALL load issue_tnew at the next edge.
REQ-015 SHALL, on wb_we with wb_a3 != 0 and cnt[wb_a3] != 0, decrement cnt[wb_a3]; wb_we to a register with cnt == 0 SHALL be ignored.
REQ-016 SHALL, when accept and write-back target the same register in one cycle, leave cnt unchanged and load tnew from issue_tnew.
REQ-017 SHALL decrement every nonzero tnew by 1 each cycle, saturating at 0, except entries loaded that cycle.
REQ-018 SHALL assert stall when issue_valid, issue_rd != 0 and cnt[issue_rd] == 3, so that cnt never overflows.
REQ-019 SHALL treat a source as hazarded when used, addr != 0, cnt[addr] != 0, and it is not exactly the last pending write being committed this cycle (wb_we, wb_a3 == addr, cnt == 1); the register file write-through covers that case.
REQ-020 SHALL have zero-cycle latency from inputs to stall, rs_fwd and rt_fwd; busy_cnt SHALL reflect state after the most recent edge.
REQ-021 SHALL keep stall, rs_fwd and rt_fwd at 0 when issue_valid is 0.

Reset
REQ-022 SHALL, while reset is high, force every cnt and tnew to 0 and busy_cnt to 0, independent of clk.
REQ-023 SHALL discard any issue or write-back presented in the cycle reset deasserts if reset is still high at that edge.

Configuration
REQ-024 SHALL honour macro SCOREBOARD_FORWARD_EN: when defined, a hazarded source SHALL stall only if tnew[addr] > its tuse and SHALL otherwise assert its *_fwd output; when undefined, any hazarded source SHALL stall and rs_fwd and rt_fwd SHALL be tied to 0.

Verification
REQ-025 SHALL cover: reset, then issue rd=8 tnew=2 with no conflict -> stall=0; busy_cnt=1 next cycle; after 2 cycles, tnew[8]=0.
REQ-026 SHALL cover: rd=8 pending with tnew=2, then a reader with rs=8, rs_tuse=0 -> stall=1; with SCOREBOARD_FORWARD_EN, the reader stalls 2 cycles and then sees rs_fwd=1 and stall=0.
REQ-027 SHALL cover: rd=8 pending with cnt=1, and in the same cycle wb_we=1, wb_a3=8 and a reader with rs=8 -> stall=0 and rs_fwd=0; busy_cnt=0 next cycle.
REQ-028 SHALL cover: three issues to rd=5 with no write-back, then a fourth issue to rd=5 -> stall=1; after one wb_a3=5, the fourth issue is accepted.
REQ-029 SHALL cover: a reader with rs=0, rs_used=1 while register 0 is targeted by issue and write-back -> stall=0, busy_cnt unchanged.
REQ-030 SHALL cover: reset asserted mid-cycle with busy_cnt=4 -> busy_cnt=0 and stall=0 immediately, without waiting for a clock edge.
